mem_stage_sram: RTL and testbench

//  MEM stage of the 5-stage pipeline, directly downstream of EX; consumes the EX/MEM register (ALU result, store value, dest, WB/MEM controls).

---
 rtl/mem_stage_sram.sv | 153 +++++++++++++++
 tb/tb_mem_stage_sram.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram.sv
// MEM stage: splits each 32-bit load/store into two 16-bit off-chip SRAM accesses and freezes the pipeline meanwhile.
// Optional build macro MEM_ADDR_CHECK_EN adds misaligned/out-of-range detection and the addr_err output.
module mem_stage_sram #(
    parameter int MEM_BASE      = 1024,
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       st_val_in,
    input  logic [4:0]        dest_in,
    output logic              wb_en_out,
    output logic              mem_read_out,
    output logic [4:0]        dest_out,
    output logic [31:0]       alu_result_out,
    output logic [31:0]       mem_data_out,
    output logic              sram_freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
`ifdef MEM_ADDR_CHECK_EN
    output logic              addr_err,
`endif
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ce_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    // state | meaning
    // IDLE  | no access in progress
    // LO    | 16-bit access of bits [15:0] at {w,0}
    // HI    | 16-bit access of bits [31:16] at {w,1}
    // DONE  | single cycle, freeze released so the pipeline advances
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 1);

    state_t            state;
    logic [2:0]        cyc_cnt;
    logic [ADDR_W-2:0] word_idx;
    logic [31:0]       st_val;
    logic              is_write;
    logic              request;
    logic [31:0]       byte_off;
    logic [ADDR_W-2:0] idx_next;
    logic              unused_off_bits;

    assign request  = mem_write_in | mem_read_in;
    assign byte_off = alu_result_in - 32'(MEM_BASE);
    // Index bits above the SRAM size are dropped, so accesses wrap inside the device.
    assign idx_next = byte_off[ADDR_W:2];

`ifdef MEM_ADDR_CHECK_EN
    localparam logic [29:0] MAX_IDX = 30'((32'd1 << (ADDR_W - 1)) - 32'd1);
    logic addr_bad;
    assign addr_bad = (alu_result_in[1:0] != 2'b00) || (alu_result_in < 32'(MEM_BASE)) ||
                      (byte_off[31:2] > MAX_IDX);
    assign unused_off_bits = ^byte_off[1:0];
`else
    assign unused_off_bits = ^{byte_off[31:ADDR_W+1], byte_off[1:0]};
`endif

    assign wb_en_out      = wb_en_in;
    assign mem_read_out   = mem_read_in;
    assign dest_out       = dest_in;
    assign alu_result_out = alu_result_in;

    assign sram_freeze = !rst && request && (state != DONE);
    assign sram_ce_n   = 1'b0;
    assign sram_ub_n   = 1'b0;
    assign sram_lb_n   = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cyc_cnt      <= 3'd0;
            word_idx     <= '0;
            st_val       <= 32'd0;
            is_write     <= 1'b0;
            sram_addr    <= '0;
            sram_dq_out  <= 16'd0;
            sram_dq_oe   <= 1'b0;
            sram_we_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            mem_data_out <= 32'd0;
`ifdef MEM_ADDR_CHECK_EN
            addr_err     <= 1'b0;
`endif
        end else begin
`ifdef MEM_ADDR_CHECK_EN
            addr_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (request) begin
`ifdef MEM_ADDR_CHECK_EN
                        if (addr_bad) begin
                            state    <= DONE;
                            addr_err <= 1'b1;
                        end else
`endif
                        begin
                            state       <= LO;
                            cyc_cnt     <= 3'd0;
                            word_idx    <= idx_next;
                            st_val      <= st_val_in;
                            is_write    <= mem_write_in;
                            sram_addr   <= {idx_next, 1'b0};
                            sram_dq_out <= st_val_in[15:0];
                            sram_dq_oe  <= mem_write_in;
                            sram_oe_n   <= mem_write_in;
                            sram_we_n   <= ~(mem_write_in && (LAST_CNT != 3'd0));
                        end
                    end
                end
                LO, HI: begin
                    if (cyc_cnt == LAST_CNT) begin
                        if (!is_write) begin
                            if (state == LO) mem_data_out[15:0]  <= sram_dq_in;
                            else             mem_data_out[31:16] <= sram_dq_in;
                        end
                        cyc_cnt <= 3'd0;
                        if (state == LO) begin
                            state       <= HI;
                            sram_addr   <= {word_idx, 1'b1};
                            sram_dq_out <= st_val[31:16];
                            sram_we_n   <= ~(is_write && (LAST_CNT != 3'd0));
                        end else begin
                            state      <= DONE;
                            sram_dq_oe <= 1'b0;
                            sram_oe_n  <= 1'b1;
                            sram_we_n  <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 3'd1;
                        // Release we_n one cycle early so data stays valid past the strobe.
                        sram_we_n <= ~(is_write && ((cyc_cnt + 3'd1) != LAST_CNT));
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram with a behavioural 16-bit SRAM and write log.
module tb_mem_stage_sram;
    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wb_en_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
    logic [31:0]       alu_result_in = 32'd0, st_val_in = 32'd0;
    logic [4:0]        dest_in = 5'd0;
    logic              wb_en_out, mem_read_out;
    logic [4:0]        dest_out;
    logic [31:0]       alu_result_out, mem_data_out;
    logic              sram_freeze;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_out, sram_dq_in;
    logic              sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
`ifdef MEM_ADDR_CHECK_EN
    logic              addr_err;
`endif

    int checks = 0;
    int passes = 0;

    logic [15:0]       sram_mem [0:255];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [15:0]       wr_data_q [$];

    always #5 clk = ~clk;

    mem_stage_sram #(.MEM_BASE(1024), .ACCESS_CYCLES(2), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .alu_result_in(alu_result_in), .st_val_in(st_val_in),
        .dest_in(dest_in), .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
        .dest_out(dest_out), .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
        .sram_freeze(sram_freeze), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe),
`ifdef MEM_ADDR_CHECK_EN
        .addr_err(addr_err),
`endif
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    assign sram_dq_in = !sram_oe_n ? sram_mem[sram_addr[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr[7:0]] <= sram_dq_out;
            wr_addr_q.push_back(sram_addr);
            wr_data_q.push_back(sram_dq_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
    endtask

    // Walks one access from its IDLE request cycle to DONE, tallying strobe activity.
    task automatic run_access(output int fz, output int we_lo, output int oe_lo,
                              output int cyc, output bit to);
        fz = 0; we_lo = 0; oe_lo = 0; cyc = 0; to = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            cyc = i + 1;
            if (sram_freeze) fz++;
            if (!sram_we_n) we_lo++;
            if (!sram_oe_n) oe_lo++;
            if (!sram_freeze) begin
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (sram_freeze !== 1'b0) $display("FAIL reset_freeze got %0b want 0", sram_freeze); else passes++;
        checks++; if (sram_we_n !== 1'b1) $display("FAIL reset_we_n got %0b want 1", sram_we_n); else passes++;
        checks++; if (sram_oe_n !== 1'b1) $display("FAIL reset_oe_n got %0b want 1", sram_oe_n); else passes++;
        checks++; if (sram_dq_oe !== 1'b0) $display("FAIL reset_dq_oe got %0b want 0", sram_dq_oe); else passes++;
        checks++; if (sram_addr !== 18'd0) $display("FAIL reset_addr got %h want 0", sram_addr); else passes++;
        checks++; if (mem_data_out !== 32'd0) $display("FAIL reset_mem_data got %h want 0", mem_data_out); else passes++;
        checks++; if (sram_ce_n !== 1'b0 || sram_ub_n !== 1'b0 || sram_lb_n !== 1'b0)
            $display("FAIL reset_tied_enables got %b%b%b want 000", sram_ce_n, sram_ub_n, sram_lb_n); else passes++;
    endtask

    task automatic test_store();
        int fz, we_lo, oe_lo, cyc, n0;
        bit to;
        n0 = wr_addr_q.size();
        alu_result_in = 32'd1028; st_val_in = 32'hDEAD_BEEF; mem_write_in = 1'b1;
        run_access(fz, we_lo, oe_lo, cyc, to);
        checks++; if (to) $display("FAIL store_timeout got no DONE within 20 cycles"); else passes++;
        checks++; if (fz != 5) $display("FAIL store_freeze_cycles got %0d want 5", fz); else passes++;
        checks++; if (we_lo != 2) $display("FAIL store_we_low_cycles got %0d want 2", we_lo); else passes++;
        checks++; if (oe_lo != 0) $display("FAIL store_oe_low_cycles got %0d want 0", oe_lo); else passes++;
        checks++; if (wr_addr_q.size() != n0 + 2) $display("FAIL store_write_count got %0d want 2", wr_addr_q.size() - n0);
        else begin
            passes++;
            checks++; if (wr_addr_q[n0] !== 18'd2 || wr_data_q[n0] !== 16'hBEEF)
                $display("FAIL store_lo_half got addr %h data %h want addr 2 data beef", wr_addr_q[n0], wr_data_q[n0]); else passes++;
            checks++; if (wr_addr_q[n0+1] !== 18'd3 || wr_data_q[n0+1] !== 16'hDEAD)
                $display("FAIL store_hi_half got addr %h data %h want addr 3 data dead", wr_addr_q[n0+1], wr_data_q[n0+1]); else passes++;
        end
        checks++; if (sram_dq_oe !== 1'b0 || sram_we_n !== 1'b1)
            $display("FAIL store_done_strobes got dq_oe %0b we_n %0b want 0 1", sram_dq_oe, sram_we_n); else passes++;
        idle_inputs();
        tick();
    endtask

    task automatic test_load();
        int fz, we_lo, oe_lo, cyc;
        bit to;
        alu_result_in = 32'd1028; mem_read_in = 1'b1;
        run_access(fz, we_lo, oe_lo, cyc, to);
        checks++; if (to) $display("FAIL load_timeout got no DONE within 20 cycles"); else passes++;
        checks++; if (fz != 5 || cyc != 6) $display("FAIL load_latency got freeze %0d cycles %0d want 5 6", fz, cyc); else passes++;
        checks++; if (oe_lo != 4 || we_lo != 0) $display("FAIL load_strobes got oe_low %0d we_low %0d want 4 0", oe_lo, we_lo); else passes++;
        checks++; if (mem_data_out !== 32'hDEAD_BEEF) $display("FAIL load_data got %h want deadbeef", mem_data_out); else passes++;
        checks++; if (mem_read_out !== 1'b1) $display("FAIL load_mem_read_out got %0b want 1", mem_read_out); else passes++;
        idle_inputs();
        tick();
        checks++; if (mem_data_out !== 32'hDEAD_BEEF) $display("FAIL load_data_hold got %h want deadbeef", mem_data_out); else passes++;
    endtask

    task automatic test_reset_mid_access();
        alu_result_in = 32'd1036; st_val_in = 32'hAAAA_5555; mem_write_in = 1'b1;
        #1;
        tick();
        tick();
        checks++; if (sram_dq_oe !== 1'b1) $display("FAIL midrst_in_flight got dq_oe %0b want 1", sram_dq_oe); else passes++;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0)
            $display("FAIL midrst_strobes got we_n %0b dq_oe %0b want 1 0", sram_we_n, sram_dq_oe); else passes++;
        checks++; if (sram_freeze !== 1'b0) $display("FAIL midrst_freeze got %0b want 0", sram_freeze); else passes++;
        checks++; if (mem_data_out !== 32'd0) $display("FAIL midrst_mem_data got %h want 0", mem_data_out); else passes++;
    endtask

    task automatic test_back_to_back();
        int fz1, fz2, we_lo, oe_lo, c1, c2;
        bit to1, to2;
        alu_result_in = 32'd1032; st_val_in = 32'h1234_5678; mem_write_in = 1'b1;
        run_access(fz1, we_lo, oe_lo, c1, to1);
        mem_write_in = 1'b0; mem_read_in = 1'b1;
        tick();
        checks++; if (sram_freeze !== 1'b1 || sram_oe_n !== 1'b1 || sram_we_n !== 1'b1)
            $display("FAIL b2b_idle_gap got freeze %0b oe_n %0b we_n %0b want 1 1 1", sram_freeze, sram_oe_n, sram_we_n); else passes++;
        run_access(fz2, we_lo, oe_lo, c2, to2);
        checks++; if (to1 || to2) $display("FAIL b2b_timeout got store %0b load %0b want 0 0", to1, to2); else passes++;
        checks++; if (c1 + c2 != 12) $display("FAIL b2b_total_cycles got %0d want 12", c1 + c2); else passes++;
        checks++; if (fz1 != 5 || fz2 != 5) $display("FAIL b2b_freeze got %0d %0d want 5 5", fz1, fz2); else passes++;
        checks++; if (mem_data_out !== 32'h1234_5678) $display("FAIL b2b_load_data got %h want 12345678", mem_data_out); else passes++;
        idle_inputs();
        tick();
    endtask

    task automatic test_alu_passthrough();
        idle_inputs();
        alu_result_in = 32'h0000_0ABC; dest_in = 5'd17; wb_en_in = 1'b1;
        #1;
        checks++; if (sram_freeze !== 1'b0 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0)
            $display("FAIL alu_strobes got freeze %0b we_n %0b oe_n %0b dq_oe %0b want 0 1 1 0",
                     sram_freeze, sram_we_n, sram_oe_n, sram_dq_oe); else passes++;
        checks++; if (alu_result_out !== 32'h0000_0ABC || dest_out !== 5'd17 || wb_en_out !== 1'b1)
            $display("FAIL alu_pass_a got %h %0d %0b want abc 17 1", alu_result_out, dest_out, wb_en_out); else passes++;
        alu_result_in = 32'hFFFF_0000; dest_in = 5'd3; wb_en_in = 1'b0;
        #1;
        checks++; if (alu_result_out !== 32'hFFFF_0000 || dest_out !== 5'd3 || wb_en_out !== 1'b0)
            $display("FAIL alu_pass_b got %h %0d %0b want ffff0000 3 0", alu_result_out, dest_out, wb_en_out); else passes++;
        checks++; if (mem_read_out !== 1'b0) $display("FAIL alu_mem_read_out got %0b want 0", mem_read_out); else passes++;
        tick();
        checks++; if (sram_freeze !== 1'b0 || sram_oe_n !== 1'b1 || mem_data_out !== 32'h1234_5678)
            $display("FAIL alu_no_access got freeze %0b oe_n %0b data %h want 0 1 12345678",
                     sram_freeze, sram_oe_n, mem_data_out); else passes++;
    endtask

`ifdef MEM_ADDR_CHECK_EN
    task automatic test_addr_err();
        int n0;
        n0 = wr_addr_q.size();
        alu_result_in = 32'd1026; mem_read_in = 1'b1;
        #1;
        checks++; if (sram_freeze !== 1'b1) $display("FAIL err_idle_freeze got %0b want 1", sram_freeze); else passes++;
        tick();
        checks++; if (sram_freeze !== 1'b0 || addr_err !== 1'b1)
            $display("FAIL err_done got freeze %0b addr_err %0b want 0 1", sram_freeze, addr_err); else passes++;
        checks++; if (sram_oe_n !== 1'b1 || mem_data_out !== 32'h1234_5678)
            $display("FAIL err_no_read got oe_n %0b data %h want 1 12345678", sram_oe_n, mem_data_out); else passes++;
        idle_inputs();
        tick();
        checks++; if (addr_err !== 1'b0) $display("FAIL err_one_cycle got %0b want 0", addr_err); else passes++;
        alu_result_in = 32'd1020; st_val_in = 32'h0BAD_F00D; mem_write_in = 1'b1;
        tick();
        checks++; if (addr_err !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0)
            $display("FAIL err_below_base got addr_err %0b we_n %0b dq_oe %0b want 1 1 0", addr_err, sram_we_n, sram_dq_oe); else passes++;
        idle_inputs();
        tick();
        checks++; if (wr_addr_q.size() != n0) $display("FAIL err_no_write got %0d writes want 0", wr_addr_q.size() - n0); else passes++;
    endtask
`else
    task automatic test_addr_wrap();
        int fz, we_lo, oe_lo, cyc, n0;
        bit to;
        alu_result_in = 32'd1024; st_val_in = 32'h2222_1111; mem_write_in = 1'b1;
        run_access(fz, we_lo, oe_lo, cyc, to);
        idle_inputs();
        tick();
        alu_result_in = 32'd1026; mem_read_in = 1'b1;
        run_access(fz, we_lo, oe_lo, cyc, to);
        checks++; if (to) $display("FAIL wrap_timeout got no DONE within 20 cycles"); else passes++;
        checks++; if (mem_data_out !== 32'h2222_1111) $display("FAIL wrap_unaligned_load got %h want 22221111", mem_data_out); else passes++;
        idle_inputs();
        tick();
        n0 = wr_addr_q.size();
        alu_result_in = 32'd1020; st_val_in = 32'h0BAD_F00D; mem_write_in = 1'b1;
        run_access(fz, we_lo, oe_lo, cyc, to);
        checks++; if (wr_addr_q.size() != n0 + 2) $display("FAIL wrap_write_count got %0d want 2", wr_addr_q.size() - n0);
        else begin
            passes++;
            checks++; if (wr_addr_q[n0] !== 18'h3FFFE || wr_data_q[n0] !== 16'hF00D)
                $display("FAIL wrap_lo got addr %h data %h want 3fffe f00d", wr_addr_q[n0], wr_data_q[n0]); else passes++;
            checks++; if (wr_addr_q[n0+1] !== 18'h3FFFF || wr_data_q[n0+1] !== 16'h0BAD)
                $display("FAIL wrap_hi got addr %h data %h want 3ffff 0bad", wr_addr_q[n0+1], wr_data_q[n0+1]); else passes++;
        end
        idle_inputs();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_load();
        test_reset_mid_access();
        test_back_to_back();
        test_alu_passthrough();
`ifdef MEM_ADDR_CHECK_EN
        test_addr_err();
`else
        test_addr_wrap();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
